// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, buffered MDU/load results round-robin, starvation stall.
// Define REGARB_SCOREBOARD_EN to drive o_pend_mask from buffered destinations; otherwise it is tied to 0.
module regfile_write_arbiter #(
  parameter int QDEPTH       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_reg,
  input  logic [3:0]  i_wb_be,
  input  logic [31:0] i_wb_data,
  input  logic        i_mdu_valid,
  output logic        o_mdu_ready,
  input  logic [4:0]  i_mdu_reg,
  input  logic [31:0] i_mdu_data,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [4:0]  i_ld_reg,
  input  logic [3:0]  i_ld_be,
  input  logic [31:0] i_ld_data,
  output logic [3:0]  o_rf_write,
  output logic [4:0]  o_rf_reg,
  output logic [31:0] o_rf_data,
  output logic        o_stall_req,
  output logic [31:0] o_pend_mask
);
  localparam int            AW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int            CW    = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);
  localparam logic [3:0]    LIMIT = 4'(STARVE_LIMIT);
  localparam int            MDU   = 0;
  localparam int            LD    = 1;

  typedef struct packed {
    logic [4:0]  rg;
    logic [3:0]  be;
    logic [31:0] dat;
  } wr_t;

  wr_t           r_mem [2][QDEPTH];
  logic [AW-1:0] r_rd_ptr [2];
  logic [AW-1:0] r_wr_ptr [2];
  logic [CW-1:0] r_count [2];
  logic [3:0]    r_starve [2];
  logic          r_rr_last;
  logic [3:0]    r_rf_write;
  logic [4:0]    r_rf_reg;
  logic [31:0]   r_rf_data;
  logic          r_stall;

  wr_t        w_in [2];
  wr_t        w_head [2];
  wr_t        w_win;
  logic [1:0] w_valid;
  logic [1:0] w_ready;
  logic [1:0] w_push;
  logic [1:0] w_head_vld;
  logic [1:0] w_grant;
  logic       w_wb_act;
  logic [3:0] w_starve_nxt [2];
  logic [31:0] w_pend;

  assign w_in[MDU] = '{rg: i_mdu_reg, be: 4'hF,    dat: i_mdu_data};
  assign w_in[LD]  = '{rg: i_ld_reg,  be: i_ld_be, dat: i_ld_data};
  assign w_valid   = {i_ld_valid, i_mdu_valid};
  assign w_wb_act  = i_wb_valid && (i_wb_reg != 5'd0) && (i_wb_be != 4'd0);

  // Writes to r0 or with no byte lanes are handshaken but dropped here.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_ready[s]    = r_count[s] < DEPTH;
      w_head_vld[s] = r_count[s] != '0;
      w_head[s]     = r_mem[s][r_rd_ptr[s]];
      w_push[s]     = w_valid[s] && w_ready[s] && (w_in[s].rg != 5'd0) && (w_in[s].be != 4'd0);
    end
  end

  // r_rr_last = 1 means LD was granted last, so MDU wins a tie.
  always_comb begin
    w_grant = 2'b00;
    if (!w_wb_act) begin
      if (&w_head_vld) w_grant = r_rr_last ? 2'b01 : 2'b10;
      else             w_grant = w_head_vld;
    end
  end

  always_comb begin
    w_win = w_grant[MDU] ? w_head[MDU] : w_head[LD];
    if (w_wb_act) w_win = '{rg: i_wb_reg, be: i_wb_be, dat: i_wb_data};
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_starve_nxt[s] = 4'd0;
      if (w_head_vld[s] && !w_grant[s])
        w_starve_nxt[s] = (r_starve[s] == LIMIT) ? LIMIT : r_starve[s] + 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < 2; s++) begin
        r_rd_ptr[s] <= '0;
        r_wr_ptr[s] <= '0;
        r_count[s]  <= '0;
        r_starve[s] <= '0;
      end
      r_rr_last  <= 1'b1;
      r_rf_write <= '0;
      r_rf_reg   <= '0;
      r_rf_data  <= '0;
      r_stall    <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_push[s])  r_wr_ptr[s] <= r_wr_ptr[s] + AW'(1);
        if (w_grant[s]) r_rd_ptr[s] <= r_rd_ptr[s] + AW'(1);
        r_count[s]  <= r_count[s] + CW'(w_push[s]) - CW'(w_grant[s]);
        r_starve[s] <= w_starve_nxt[s];
      end
      if (|w_grant) r_rr_last <= w_grant[LD];
      r_stall    <= (w_starve_nxt[MDU] == LIMIT) || (w_starve_nxt[LD] == LIMIT);
      r_rf_write <= '0;
      if (w_wb_act || (|w_grant)) begin
        r_rf_write <= w_win.be;
        r_rf_reg   <= w_win.rg;
        r_rf_data  <= w_win.dat;
      end
    end
  end

  // Storage carries no reset; occupancy is tracked solely by r_count.
  always_ff @(posedge i_clk) begin
    for (int s = 0; s < 2; s++)
      if (w_push[s]) r_mem[s][r_wr_ptr[s]] <= w_in[s];
  end

`ifdef REGARB_SCOREBOARD_EN
  logic [AW-1:0] w_off;

  always_comb begin
    w_pend = '0;
    w_off  = '0;
    for (int s = 0; s < 2; s++) begin
      for (int e = 0; e < QDEPTH; e++) begin
        w_off = AW'(e) - r_rd_ptr[s];
        if ({1'b0, w_off} < r_count[s]) w_pend[r_mem[s][e].rg] = 1'b1;
      end
    end
  end
`else
  assign w_pend = '0;
`endif

  assign o_mdu_ready = w_ready[MDU];
  assign o_ld_ready  = w_ready[LD];
  assign o_rf_write  = r_rf_write;
  assign o_rf_reg    = r_rf_reg;
  assign o_rf_data   = r_rf_data;
  assign o_stall_req = r_stall;
  assign o_pend_mask = w_pend;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: wb vector table, scoreboard of rf writes, FIFO corner sequences.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, mdu_valid, ld_valid;
  logic [4:0]  wb_reg, mdu_reg, ld_reg;
  logic [3:0]  wb_be, ld_be;
  logic [31:0] wb_data, mdu_data, ld_data;
  logic        mdu_ready, ld_ready, stall_req;
  logic [3:0]  rf_write;
  logic [4:0]  rf_reg;
  logic [31:0] rf_data, pend_mask;

  regfile_write_arbiter #(.QDEPTH(2), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_valid(wb_valid), .i_wb_reg(wb_reg), .i_wb_be(wb_be), .i_wb_data(wb_data),
    .i_mdu_valid(mdu_valid), .o_mdu_ready(mdu_ready), .i_mdu_reg(mdu_reg), .i_mdu_data(mdu_data),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_reg(ld_reg), .i_ld_be(ld_be), .i_ld_data(ld_data),
    .o_rf_write(rf_write), .o_rf_reg(rf_reg), .o_rf_data(rf_data),
    .o_stall_req(stall_req), .o_pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  be;
    logic [4:0]  rg;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    logic        vld;
    logic [4:0]  rg;
    logic [3:0]  be;
    logic [31:0] dat;
    logic [3:0]  exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_dat;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pexp(input logic [31:0] m);
`ifdef REGARB_SCOREBOARD_EN
    return m;
`else
    return m & 32'h0;
`endif
  endfunction

  task automatic push_exp(input logic [3:0] be, input logic [4:0] rg, input logic [31:0] dat);
    exp_t e;
    e.be = be; e.rg = rg; e.dat = dat;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_reg = '0; wb_be = '0; wb_data = '0;
    mdu_valid = 1'b0; mdu_reg = '0; mdu_data = '0;
    ld_valid = 1'b0; ld_reg = '0; ld_be = '0; ld_data = '0;
  endtask

  // Every rf write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rf_write !== 4'h0) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got be=%h reg=%0d data=%h, required no write", rf_write, rf_reg, rf_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_be",   32'(rf_write), 32'(mon_e.be));
        chk("sb_reg",  32'(rf_reg),   32'(mon_e.rg));
        chk("sb_data", rf_data,       mon_e.dat);
      end
    end
  end

  task automatic fill(input logic [4:0] m0, input logic [4:0] m1, input logic [4:0] l0, input logic [4:0] l1,
                      input logic [3:0] lbe1, input logic [31:0] base);
    for (int k = 0; k < 2; k++) begin
      wb_valid = 1'b1; wb_reg = 5'd2; wb_be = 4'hF; wb_data = base + 32'(k);
      push_exp(4'hF, 5'd2, base + 32'(k));
      mdu_valid = 1'b1; mdu_reg = (k == 0) ? m0 : m1; mdu_data = base + 32'h100 + 32'(k);
      ld_valid = 1'b1; ld_reg = (k == 0) ? l0 : l1; ld_be = (k == 0) ? 4'hF : lbe1;
      ld_data = base + 32'h200 + 32'(k);
      tick();
    end
    idle();
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  4'hF, 32'hDEADBEEF, 4'hF, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd0,  4'hF, 32'h12345678, 4'h0, 5'd5,  32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd7,  4'h0, 32'hCAFEF00D, 4'h0, 5'd5,  32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd9,  4'hF, 32'h0BADC0DE, 4'h0, 5'd5,  32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd31, 4'h5, 32'hA5A5A5A5, 4'h5, 5'd31, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 5'd1,  4'h8, 32'h00000080, 4'h8, 5'd1,  32'h00000080};
    vecs[6] = '{1'b1, 5'd9,  4'hF, 32'h13572468, 4'hF, 5'd9,  32'h13572468};

    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rf_write",  32'(rf_write),  32'h0);
    chk("rst_rf_reg",    32'(rf_reg),    32'h0);
    chk("rst_rf_data",   rf_data,        32'h0);
    chk("rst_stall",     32'(stall_req), 32'h0);
    chk("rst_pend",      pend_mask,      32'h0);
    chk("rst_mdu_ready", 32'(mdu_ready), 32'h1);
    chk("rst_ld_ready",  32'(ld_ready),  32'h1);
    rst = 1'b0;

    // Pipeline writeback vectors, latency one.
    for (int i = 0; i < 7; i++) begin
      wb_valid = vecs[i].vld; wb_reg = vecs[i].rg; wb_be = vecs[i].be; wb_data = vecs[i].dat;
      if (vecs[i].exp_we != 4'h0) push_exp(vecs[i].exp_we, vecs[i].exp_reg, vecs[i].exp_dat);
      tick();
      chk("vec_rf_write", 32'(rf_write), 32'(vecs[i].exp_we));
      chk("vec_rf_reg",   32'(rf_reg),   32'(vecs[i].exp_reg));
      chk("vec_rf_data",  rf_data,       vecs[i].exp_dat);
      if (i == 0) begin
        chk("vec_mdu_ready", 32'(mdu_ready), 32'h1);
        chk("vec_ld_ready",  32'(ld_ready),  32'h1);
      end
    end
    idle();
    tick();

    // Simultaneous MDU and load push, wb idle.
    mdu_valid = 1'b1; mdu_reg = 5'd3; mdu_data = 32'h11;
    ld_valid = 1'b1; ld_reg = 5'd4; ld_be = 4'b0011; ld_data = 32'h22;
    push_exp(4'hF, 5'd3, 32'h11);
    push_exp(4'b0011, 5'd4, 32'h22);
    tick();
    idle();
    chk("dual_pend_t1",  pend_mask,     pexp(32'h18));
    chk("dual_we_t1",    32'(rf_write), 32'h0);
    tick();
    chk("dual_pend_t2",  pend_mask,     pexp(32'h10));
    chk("dual_we_t2",    32'(rf_write), 32'hF);
    chk("dual_reg_t2",   32'(rf_reg),   32'd3);
    tick();
    chk("dual_pend_t3",  pend_mask,     32'h0);
    chk("dual_we_t3",    32'(rf_write), 32'h3);
    chk("dual_reg_t3",   32'(rf_reg),   32'd4);
    chk("dual_data_t3",  rf_data,       32'h22);
    tick();
    chk("dual_we_t4",    32'(rf_write), 32'h0);

    // MDU starvation under continuous writeback.
    for (int k = 0; k < 5; k++) begin
      wb_valid = 1'b1; wb_reg = 5'd2; wb_be = 4'hF; wb_data = 32'hB0000000 + 32'(k);
      push_exp(4'hF, 5'd2, 32'hB0000000 + 32'(k));
      mdu_valid = (k < 3); mdu_reg = 5'd10 + 5'(k); mdu_data = 32'hA0 + 32'(k);
      tick();
      chk("starve_stall", 32'(stall_req), (k == 4) ? 32'd1 : 32'd0);
      chk("starve_ready", 32'(mdu_ready), (k == 0) ? 32'd1 : 32'd0);
      chk("starve_pend",  pend_mask,      pexp((k == 0) ? 32'h400 : 32'hC00));
    end
    idle();
    push_exp(4'hF, 5'd10, 32'hA0);
    tick();
    chk("starve_drop",   32'(stall_req), 32'h0);
    chk("starve_grant",  32'(rf_reg),    32'd10);
    chk("starve_ready2", 32'(mdu_ready), 32'h1);
    push_exp(4'hF, 5'd11, 32'hA1);
    tick();
    chk("starve_grant2", 32'(rf_reg),    32'd11);
    chk("starve_pend2",  pend_mask,      32'h0);
    tick();

    // Writes to r0 or with zero byte enables are dropped everywhere.
    for (int k = 0; k < 2; k++) begin
      wb_valid = 1'b1; wb_reg = (k == 0) ? 5'd0 : 5'd6; wb_be = (k == 0) ? 4'hF : 4'h0; wb_data = 32'h5555;
      mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'h6666;
      ld_valid = 1'b1; ld_reg = (k == 0) ? 5'd0 : 5'd5; ld_be = (k == 0) ? 4'hF : 4'h0; ld_data = 32'h7777;
      tick();
      chk("zero_pend", pend_mask,     32'h0);
      chk("zero_we",   32'(rf_write), 32'h0);
    end
    idle();
    tick();
    chk("zero_we_after",  32'(rf_write),  32'h0);
    chk("zero_mdu_ready", 32'(mdu_ready), 32'h1);
    chk("zero_ld_ready",  32'(ld_ready),  32'h1);

    // Reset while both FIFOs hold data; last FIFO grant was MDU so LD drains first.
    fill(5'd6, 5'd7, 5'd8, 5'd9, 4'hC, 32'hC000);
    chk("full_mdu_ready", 32'(mdu_ready), 32'h0);
    chk("full_ld_ready",  32'(ld_ready),  32'h0);
    chk("full_pend",      pend_mask,      pexp(32'h3C0));
    push_exp(4'hF, 5'd8, 32'hC200);
    tick();
    chk("drain_reg",  32'(rf_reg), 32'd8);
    chk("drain_pend", pend_mask,   pexp(32'h2C0));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_rf_write",  32'(rf_write),  32'h0);
    chk("arst_rf_reg",    32'(rf_reg),    32'h0);
    chk("arst_rf_data",   rf_data,        32'h0);
    chk("arst_stall",     32'(stall_req), 32'h0);
    chk("arst_pend",      pend_mask,      32'h0);
    chk("arst_mdu_ready", 32'(mdu_ready), 32'h1);
    chk("arst_ld_ready",  32'(ld_ready),  32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_we", 32'(rf_write), 32'h0);
    end
    chk("post_rst_mdu_ready", 32'(mdu_ready), 32'h1);
    chk("post_rst_ld_ready",  32'(ld_ready),  32'h1);

    // After reset, round-robin starts with MDU and alternates.
    fill(5'd12, 5'd13, 5'd14, 5'd15, 4'h6, 32'hE000);
    push_exp(4'hF, 5'd12, 32'hE100);
    push_exp(4'hF, 5'd14, 32'hE200);
    push_exp(4'hF, 5'd13, 32'hE101);
    push_exp(4'h6, 5'd15, 32'hE201);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_reg", 32'(rf_reg), (k == 0) ? 32'd12 : (k == 1) ? 32'd14 : (k == 2) ? 32'd13 : 32'd15);
    end
    tick();
    chk("rr_idle_we", 32'(rf_write), 32'h0);
    chk("rr_pend",    pend_mask,     32'h0);
    chk("rr_stall",   32'(stall_req), 32'h0);

    @(negedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequences the single write port of the 32×32 general register file between three producers: the in-order pipeline writeback, the multi-cycle multiply/divide unit (MDU) and the late load-return path. Pipeline writeback has fixed top priority and is never back-pressured. MDU and load results are buffered in small per-source FIFOs and drained round-robin into idle port cycles. A starvation counter requests a one-cycle pipeline writeback bubble when a buffered result has waited too long. The block sits between the writeback stage and the register file's Write/regWrite/datain inputs.

## Interface
- QDEPTH, 2: entries per source FIFO; power of two, ≥2.
- STARVE_LIMIT, 4: cycles a valid FIFO head may lose arbitration before stall_req asserts; range 1..15.
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- wb_valid  in  1  pipeline writeback request; always accepted.
- wb_reg  in  5  destination register.
- wb_be  in  4  byte enables, bit i covers bits [8i+7:8i].
- wb_data  in  32  write data.
- mdu_valid  in  1  MDU result valid.
- mdu_ready  out  1  MDU FIFO can accept.
- mdu_reg  in  5  destination register.
- mdu_data  in  32  full-word result; byte enables are implicitly 4'b1111.
- ld_valid  in  1  load-return valid.
- ld_ready  out  1  load FIFO can accept.
- ld_reg  in  5  destination register.
- ld_be  in  4  byte enables.
- ld_data  in  32  load data, already lane-aligned.
- rf_write  out  4  register file byte write enables.
- rf_reg  out  5  register file write address.
- rf_data  out  32  register file write data.
- stall_req  out  1  asks the pipeline to hold wb_valid low next cycle.
- pend_mask  out  32  bit r set while any buffered write targets register r.

## Operation
- Reset values: rf_write=0, rf_reg=0, rf_data=0, stall_req=0, pend_mask=0, both FIFOs empty, mdu_ready=ld_ready=1, round-robin pointer=LD (so MDU wins the first tie), starvation counters=0.
- A push occurs when valid && ready. A push with reg==0 or be==0 is accepted but not stored.
- ready = FIFO count < QDEPTH, derived from registered state only. When the FIFO is full, ready is low, so a pop and a push cannot coincide at full.
- A wb request with wb_reg==0 or wb_be==0 counts as idle and does not occupy the port.
- Per-cycle grant:
  - non-idle wb_valid wins;
  - otherwise, if exactly one FIFO head is valid, that head wins;
  - if both are valid, the source not granted last wins, and the pointer updates only on FIFO grants.
- A granted head pops in the same cycle.
- The registered rf_* outputs take the granted request. With no grant, rf_write=0 and rf_reg/rf_data hold their previous values.
- Starvation: each source counter increments while its head is valid and not granted, and clears on grant or when the FIFO is empty. stall_req is registered and goes high the cycle after any counter reaches STARVE_LIMIT.
- While stall_req is high, the pipeline guarantees wb_valid=0. The starved head is granted in that cycle (on a double starvation, the round-robin rule picks one), the counter clears, and stall_req drops.
- pend_mask is the OR over valid entries of both FIFOs, combinational from FIFO state. It excludes the write currently on rf_*.

## Timing
- wb request in cycle t → rf_* in cycle t+1 (latency 1).
- FIFO push in cycle t → earliest grant t+1 → rf_* at t+2.
- pend_mask bit sets in t+1 after a push at t, and clears in the cycle after the entry pops.
- Throughput: one register write per cycle. Each FIFO sustains one push per cycle while it is being drained.
- RST asserted mid-operation: all state clears immediately and buffered writes are discarded. No rf_write pulse occurs during or on release of reset.

## Configuration
- REGARB_SCOREBOARD_EN defined: pend_mask is generated as described; the issue stage uses it for RAW interlock against buffered results.
- Not defined: pend_mask is tied to 0 and its comparators are removed. Software or the scheduler must then guarantee no read-after-write on outstanding MDU/load destinations.

## Test plan
- Reset, then wb_valid=1, wb_reg=5, wb_be=4'hF, wb_data=32'hDEADBEEF at t → rf_write=4'hF, rf_reg=5, rf_data=32'hDEADBEEF at t+1; mdu_ready=ld_ready=1.
- mdu push (reg 3, 32'h11) and ld push (reg 4, be 4'b0011, 32'h22) in the same cycle, wb idle → MDU write at t+2, LD write at t+3; pend_mask=0x18 at t+1, then 0x10, then 0.
- Three MDU pushes on consecutive cycles with wb_valid held 1 → mdu_ready=0 after two pushes; with STARVE_LIMIT=4, stall_req rises after the fourth lost cycle; the next idle cycle issues the MDU head.
- Pushes to reg 0 from ld and mdu, plus wb to reg 0 → no rf_write pulse, pend_mask stays 0, FIFOs stay empty.
- Fill both FIFOs, assert RST for one cycle mid-drain → all outputs 0 immediately; after release, no writes issue and ready=1.
- Both heads continuously valid and wb idle → grants alternate MDU, LD, MDU, LD starting with MDU after reset.
